// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// uart_pkg
// Shared UART types and helpers for the rx core and the future tx side.
//   rx_state_t      : receiver FSM states
//   baud_div()      : rounded clk-per-tick divider for a given clock, baud and oversample
//   UART_DATA_BITS  : data bits per frame (8N1)
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    // Rounded to nearest so the tick rate error stays within half a clock per tick.
    function automatic int baud_div(input int clk_hz, input int baud, input int os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
`timescale 1ns/1ps
// uart_rx_core_if
// Byte-stream interface between the UART receiver and its consumer.
//   rx_data   : received byte, stable while rx_valid is high
//   rx_valid  : byte available, held until accepted
//   rx_ready  : consumer accepts when rx_valid & rx_ready at posedge clk
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, byte dropped because holding register was full
// Modports: master = receiver (drives data/valid/pulses), slave = consumer (drives ready).
interface uart_rx_core_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] rx_data;
    logic                      rx_valid;
    logic                      rx_ready;
    logic                      frame_err;
    logic                      overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        output rx_ready
    );

endinterface

// File: rtl/uart_baud_tick.sv
`timescale 1ns/1ps
// uart_baud_tick
// Free-running oversample tick generator: counts 0..DIV-1 and asserts tick while
// the count is DIV-1. clr forces the count back to 0 so the tick phase can be
// realigned to an external event (e.g. a detected start edge).
//   clk  in  system clock
//   rst  in  synchronous reset, active-high
//   clr  in  synchronous counter clear
//   tick out one-clock strobe every DIV clocks
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_core.sv
`timescale 1ns/1ps
// uart_rx_core
// Oversampling 8N1 UART receiver. The raw rx pin is synchronised, a falling edge
// starts a frame, the start bit is confirmed at mid-bit, 8 data bits are sampled
// LSB-first one bit period apart, and the stop bit decides between delivering the
// byte and flagging a framing error (followed by waiting out the break).
//   clk  in   system clock (CLK_HZ)
//   rst  in   synchronous reset, active-high
//   rx   in   asynchronous serial input, idle high
//   bus  master side of uart_rx_core_if (rx_data/rx_valid/rx_ready/frame_err/overrun)
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    uart_rx_core_if.master  bus
);

    localparam int DIV = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int SCW = $clog2(OVERSAMPLE);
    localparam logic [SCW-1:0] SC_HALF = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);

    logic                      r_sync1;
    logic                      r_sync2;
    logic                      w_rx_s;
    logic                      w_tick;
    logic                      w_clr;

    rx_state_t                 r_state;
    rx_state_t                 w_state_n;
    logic [SCW-1:0]            r_sc;
    logic [SCW-1:0]            w_sc_n;
    logic [2:0]                r_bi;
    logic [2:0]                w_bi_n;
    logic [UART_DATA_BITS-1:0] r_shreg;
    logic [UART_DATA_BITS-1:0] w_shreg_n;
    logic                      w_deliver;
    logic                      w_ferr;

    logic                      r_deliver;
    logic [UART_DATA_BITS-1:0] r_data;
    logic                      r_valid;
    logic                      r_ferr;
    logic                      r_ovr;

    // Two-flop synchroniser; resets to the idle line level so reset never fakes a start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // Held clear while idle, so the first tick lands DIV clocks after the start edge.
    assign w_clr = (r_state == IDLE);

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sc      <= '0;
            r_bi      <= '0;
            r_shreg   <= '0;
            r_deliver <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_sc      <= w_sc_n;
            r_bi      <= w_bi_n;
            r_shreg   <= w_shreg_n;
            r_deliver <= w_deliver;
            r_ferr    <= w_ferr;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_sc_n    = r_sc;
        w_bi_n    = r_bi;
        w_shreg_n = r_shreg;
        w_deliver = 1'b0;
        w_ferr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_n = START;
                    w_sc_n    = '0;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_sc == SC_HALF) begin
                        // A line back high at mid start bit was only a glitch.
                        if (w_rx_s) begin
                            w_state_n = IDLE;
                        end else begin
                            w_state_n = DATA;
                            w_sc_n    = '0;
                            w_bi_n    = '0;
                        end
                    end else begin
                        w_sc_n = r_sc + 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_sc == SC_LAST) begin
                        w_sc_n    = '0;
                        w_shreg_n = {w_rx_s, r_shreg[UART_DATA_BITS-1:1]};
                        w_bi_n    = r_bi + 3'd1;
                        if (r_bi == 3'd7) begin
                            w_state_n = STOP;
                        end
                    end else begin
                        w_sc_n = r_sc + 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_sc == SC_LAST) begin
                        w_sc_n = '0;
                        if (w_rx_s) begin
                            w_deliver = 1'b1;
                            w_state_n = IDLE;
                        end else begin
                            w_ferr    = 1'b1;
                            w_state_n = BREAK;
                        end
                    end else begin
                        w_sc_n = r_sc + 1'b1;
                    end
                end
            end
            BREAK: begin
                if (w_rx_s) begin
                    w_state_n = IDLE;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    // Holding register. r_shreg is untouched in IDLE/START, so it still holds the
    // completed byte during the delivery cycle even if a new start was already seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            if (r_deliver) begin
                if (!r_valid || bus.rx_ready) begin
                    r_data  <= r_shreg;
                    r_valid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_valid && bus.rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.rx_data   = r_data;
    assign bus.rx_valid  = r_valid;
    assign bus.frame_err = r_ferr;
    assign bus.overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx_core.sv
`timescale 1ns/1ps
// tb_uart_rx_core
// Drives serial frames onto rx and compares the receiver's byte stream and
// error pulses against a frame-level model of the holding register.
module tb_uart_rx_core;
    import uart_pkg::*;

    localparam real BIT_NS = 1.0e9 / 115200.0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    uart_rx_core_if u_if ();

    uart_rx_core dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (u_if)
    );

    always #10 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Monitor: observed handshakes, pulses and protocol rule violations.
    logic [7:0] got_q[$];
    int         n_ferr = 0;
    int         n_ovr  = 0;
    int         n_vcyc = 0;
    int         n_viol = 0;
    logic       p_valid = 1'b0;
    logic       p_acc   = 1'b0;
    logic       p_ferr  = 1'b0;
    logic       p_ovr   = 1'b0;
    logic [7:0] p_data  = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            if (u_if.rx_valid && u_if.rx_ready) got_q.push_back(u_if.rx_data);
            if (u_if.frame_err) n_ferr++;
            if (u_if.overrun) n_ovr++;
            if (u_if.rx_valid) n_vcyc++;
            if (u_if.frame_err && u_if.overrun) n_viol++;
            if (u_if.frame_err && p_ferr) n_viol++;
            if (u_if.overrun && p_ovr) n_viol++;
            if (p_valid && !p_acc && u_if.rx_valid && (u_if.rx_data != p_data)) n_viol++;
        end
        p_valid = u_if.rx_valid;
        p_acc   = u_if.rx_valid && u_if.rx_ready;
        p_ferr  = u_if.frame_err;
        p_ovr   = u_if.overrun;
        p_data  = u_if.rx_data;
    end

    // Frame-level model: what the consumer should see for each transmitted frame.
    logic [7:0] exp_q[$];
    int         exp_ferr = 0;
    int         exp_ovr  = 0;
    bit         m_full   = 1'b0;
    logic [7:0] m_data   = 8'h00;

    task automatic model_frame(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) begin
            exp_ferr++;
        end else if (!m_full) begin
            if (u_if.rx_ready) exp_q.push_back(b);
            else begin
                m_full = 1'b1;
                m_data = b;
            end
        end else if (u_if.rx_ready) begin
            exp_q.push_back(m_data);
            m_data = b;
        end else begin
            exp_ovr++;
        end
    endtask

    task automatic model_accept();
        if (m_full) begin
            exp_q.push_back(m_data);
            m_full = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input real bit_ns, input bit stop_val);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = stop_val;
        #(bit_ns);
    endtask

    task automatic idle_bits(input real n);
        rx = 1'b1;
        #(n * BIT_NS);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 u_if.rx_ready = v;
    endtask

    task automatic check_bytes(input string tag);
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() > 0) chk(tag, {24'h0, got_q.pop_front()}, {24'h0, e});
            else chk({tag, "_missing"}, 32'hFFFF_FFFF, {24'h0, e});
        end
        chk({tag, "_extra"}, got_q.size(), 0);
        got_q.delete();
    endtask

    task automatic chk_pulses(input string tag);
        chk({tag, "_ferr_cnt"}, n_ferr, exp_ferr);
        chk({tag, "_ovr_cnt"}, n_ovr, exp_ovr);
    endtask

    task automatic chk_outputs_reset(input string tag);
        chk({tag, "_valid"}, {31'h0, u_if.rx_valid}, 0);
        chk({tag, "_data"}, {24'h0, u_if.rx_data}, 0);
        chk({tag, "_ferr"}, {31'h0, u_if.frame_err}, 0);
        chk({tag, "_ovr"}, {31'h0, u_if.overrun}, 0);
    endtask

    initial begin
        int         v0;
        logic [7:0] rb;
        logic [7:0] pb;
        logic [7:0] skew_b[4];
        real        skew_f[4];

        u_if.rx_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_outputs_reset("reset");

        // Single byte, consumer always ready: one-cycle valid.
        idle_bits(1.0);
        v0 = n_vcyc;
        send_byte(8'hA5, BIT_NS, 1'b1);
        model_frame(8'hA5, 1'b1);
        idle_bits(1.0);
        check_bytes("a5");
        chk("a5_valid_cycles", n_vcyc - v0, 1);
        chk_pulses("a5");

        // Two back-to-back bytes with consumer stalled: first held, second dropped.
        set_ready(1'b0);
        send_byte(8'h3C, BIT_NS, 1'b1);
        model_frame(8'h3C, 1'b1);
        send_byte(8'hC3, BIT_NS, 1'b1);
        model_frame(8'hC3, 1'b1);
        @(negedge clk);
        chk("hold_valid", {31'h0, u_if.rx_valid}, 1);
        chk("hold_data", {24'h0, u_if.rx_data}, 32'h3C);
        chk_pulses("hold");
        set_ready(1'b1);
        model_accept();
        set_ready(1'b0);
        @(negedge clk);
        chk("hold_valid_after_ready", {31'h0, u_if.rx_valid}, 0);
        check_bytes("hold");
        set_ready(1'b1);

        // Stop bit low, then 20 bit times of break, then a clean byte.
        idle_bits(1.0);
        v0 = n_vcyc;
        send_byte(8'h55, BIT_NS, 1'b0);
        model_frame(8'h55, 1'b0);
        #(20.0 * BIT_NS);
        idle_bits(1.0);
        chk("brk_valid_cycles", n_vcyc - v0, 0);
        chk_pulses("brk");
        send_byte(8'h12, BIT_NS, 1'b1);
        model_frame(8'h12, 1'b1);
        idle_bits(1.0);
        check_bytes("after_brk");

        // 200 ns glitch on the idle line, then a byte one bit time later.
        v0 = n_vcyc;
        rx = 1'b0;
        #200;
        rx = 1'b1;
        #(BIT_NS);
        chk("glitch_valid_cycles", n_vcyc - v0, 0);
        chk_pulses("glitch");
        rb = 8'($urandom_range(0, 255));
        send_byte(rb, BIT_NS, 1'b1);
        model_frame(rb, 1'b1);
        idle_bits(1.0);
        check_bytes("after_glitch");

        // Reset in the middle of bit 4 while a byte is held.
        set_ready(1'b0);
        send_byte(8'h96, BIT_NS, 1'b1);
        model_frame(8'h96, 1'b1);
        idle_bits(1.0);
        pb = 8'($urandom_range(0, 255));
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx = pb[i];
            #(BIT_NS);
        end
        rx = pb[4];
        #(BIT_NS / 2.0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        rx = 1'b1;
        m_full = 1'b0;
        @(negedge clk);
        chk_outputs_reset("midreset");
        v0 = n_vcyc;
        idle_bits(2.0);
        chk("midreset_valid_cycles", n_vcyc - v0, 0);
        chk_pulses("midreset");
        got_q.delete();
        set_ready(1'b1);
        send_byte(8'hF0, BIT_NS, 1'b1);
        model_frame(8'hF0, 1'b1);
        idle_bits(1.0);
        check_bytes("f0");

        // Baud skew of +/-2 % on all-zero and all-one bytes.
        skew_b = '{8'h00, 8'h00, 8'hFF, 8'hFF};
        skew_f = '{0.98, 1.02, 0.98, 1.02};
        for (int k = 0; k < 4; k++) begin
            send_byte(skew_b[k], BIT_NS * skew_f[k], 1'b1);
            model_frame(skew_b[k], 1'b1);
            idle_bits(1.0);
            check_bytes($sformatf("skew%0d", k));
        end

        // A couple of random bytes at nominal rate.
        for (int k = 0; k < 2; k++) begin
            rb = 8'($urandom_range(0, 255));
            send_byte(rb, BIT_NS, 1'b1);
            model_frame(rb, 1'b1);
            idle_bits(0.5);
        end
        idle_bits(0.5);
        check_bytes("rand");

        chk("protocol_violations", n_viol, 0);
        chk_pulses("final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
